// File: rtl/tile_sched_pkg.sv
// Shared types for the tile scheduler: FSM states, ping-pong bank states, bank count.
package tile_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        LOADING   = 2'd1,
        FULL      = 2'd2,
        COMPUTING = 2'd3
    } bank_state_t;

    localparam int BANKS = 2;

endpackage

// File: rtl/tile_bank_track.sv
// Per-bank occupancy tracking for the ping-pong buffer: bank state machines,
// load/compute pointers, outstanding-operation bookkeeping and protocol error flag.
module tile_bank_track
    import tile_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ld_fire,
    input  logic cp_fire,
    input  logic ld_done,
    input  logic cp_done,
    output logic ld_ptr,
    output logic cp_ptr,
    output logic ld_bank_empty,
    output logic cp_bank_full,
    output logic ld_busy,
    output logic cp_busy,
    output logic proto_err
);

    bank_state_t bank_state_reg [BANKS];
    logic ld_ptr_reg;
    logic cp_ptr_reg;
    logic ld_busy_reg;
    logic cp_busy_reg;
    logic ld_out_bank_reg;
    logic cp_out_bank_reg;
    logic proto_err_reg;

    // A done pulse only counts when an operation of that kind is actually outstanding.
    logic ld_done_ok;
    logic cp_done_ok;
    logic proto_bad;

    assign ld_done_ok = ld_done && ld_busy_reg;
    assign cp_done_ok = cp_done && cp_busy_reg;
    assign proto_bad  = (ld_done && !ld_busy_reg) || (cp_done && !cp_busy_reg) ||
                        (ld_done_ok && cp_done_ok && (ld_out_bank_reg == cp_out_bank_reg));

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            // Bank lifecycle: EMPTY -> LOADING -> FULL -> COMPUTING -> EMPTY.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    bank_state_reg[gi] <= EMPTY;
                end else if (ld_fire && (ld_ptr_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= LOADING;
                end else if (ld_done_ok && (ld_out_bank_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= FULL;
                end else if (cp_fire && (cp_ptr_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= COMPUTING;
                end else if (cp_done_ok && (cp_out_bank_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= EMPTY;
                end
            end
        end
    endgenerate

    // Pointers toggle on their own ack; outstanding flags remember which bank is in flight.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ld_ptr_reg      <= 1'b0;
            cp_ptr_reg      <= 1'b0;
            ld_busy_reg     <= 1'b0;
            cp_busy_reg     <= 1'b0;
            ld_out_bank_reg <= 1'b0;
            cp_out_bank_reg <= 1'b0;
        end else begin
            if (ld_fire) begin
                ld_ptr_reg      <= ~ld_ptr_reg;
                ld_out_bank_reg <= ld_ptr_reg;
                ld_busy_reg     <= 1'b1;
            end else if (ld_done_ok) begin
                ld_busy_reg     <= 1'b0;
            end
            if (cp_fire) begin
                cp_ptr_reg      <= ~cp_ptr_reg;
                cp_out_bank_reg <= cp_ptr_reg;
                cp_busy_reg     <= 1'b1;
            end else if (cp_done_ok) begin
                cp_busy_reg     <= 1'b0;
            end
        end
    end

    // Sticky protocol error; a new layer start clears it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            proto_err_reg <= 1'b0;
        end else if (proto_bad) begin
            proto_err_reg <= 1'b1;
        end
    end

    assign ld_ptr        = ld_ptr_reg;
    assign cp_ptr        = cp_ptr_reg;
    assign ld_bank_empty = (bank_state_reg[ld_ptr_reg] == EMPTY);
    assign cp_bank_full  = (bank_state_reg[cp_ptr_reg] == FULL);
    assign ld_busy       = ld_busy_reg;
    assign cp_busy       = cp_busy_reg;
    assign proto_err     = proto_err_reg;

endmodule

// File: rtl/tile_sched.sv
// Tile scheduler for the 2-bank ping-pong input buffer: issues tile loads and
// computes so a bank is never written while being read.
// Optional stall counters are built when PERF_CNT_EN is defined.
module tile_sched
    import tile_sched_pkg::*;
#(
    parameter int Tile_Cnt_Width = 10
`ifdef PERF_CNT_EN
    , parameter int Perf_Width   = 32
`endif
) (
    input  logic                      clki,
    input  logic                      rst,
    input  logic                      start,
    input  logic [Tile_Cnt_Width-1:0] num_tiles,
    output logic                      ld_req,
    input  logic                      ld_ack,
    output logic                      ld_bank,
    output logic [Tile_Cnt_Width-1:0] ld_tile_idx,
    input  logic                      ld_done,
    output logic                      cp_req,
    input  logic                      cp_ack,
    output logic                      cp_bank,
    output logic [Tile_Cnt_Width-1:0] cp_tile_idx,
    output logic                      cp_last,
    input  logic                      cp_done,
`ifdef PERF_CNT_EN
    output logic [Perf_Width-1:0]     stall_ld,
    output logic [Perf_Width-1:0]     stall_cp,
`endif
    output logic                      busy,
    output logic                      layer_done,
    output logic                      proto_err
);

    localparam int TCW = Tile_Cnt_Width;

    state_t         state_reg;
    state_t         state_next;
    logic [TCW-1:0] num_tiles_reg;
    logic [TCW-1:0] ld_cnt_reg;
    logic [TCW-1:0] cp_cnt_reg;
    logic           ld_req_reg;
    logic           ld_bank_reg;
    logic [TCW-1:0] ld_idx_reg;
    logic           cp_req_reg;
    logic           cp_bank_reg;
    logic [TCW-1:0] cp_idx_reg;
    logic           cp_last_reg;
    logic           cp_last_out_reg;

    logic start_acc;
    logic ld_fire;
    logic cp_fire;
    logic ld_ptr;
    logic cp_ptr;
    logic ld_bank_empty;
    logic cp_bank_full;
    logic ld_busy;
    logic cp_busy;
    logic ld_issue;
    logic cp_issue;
    logic last_done;

    assign start_acc = start && (state_reg == S_IDLE);
    assign ld_fire   = ld_req_reg && ld_ack;
    assign cp_fire   = cp_req_reg && cp_ack;
    assign ld_issue  = (state_reg == S_RUN) && !ld_req_reg && !ld_busy && ld_bank_empty &&
                       (ld_cnt_reg < num_tiles_reg);
    assign cp_issue  = (state_reg == S_RUN) && !cp_req_reg && !cp_busy && cp_bank_full &&
                       (cp_cnt_reg < num_tiles_reg);
    assign last_done = (state_reg == S_RUN) && cp_done && cp_busy && cp_last_out_reg;

    tile_bank_track u_track (
        .clk           (clki),
        .rst           (rst),
        .clr           (start_acc),
        .ld_fire       (ld_fire),
        .cp_fire       (cp_fire),
        .ld_done       (ld_done),
        .cp_done       (cp_done),
        .ld_ptr        (ld_ptr),
        .cp_ptr        (cp_ptr),
        .ld_bank_empty (ld_bank_empty),
        .cp_bank_full  (cp_bank_full),
        .ld_busy       (ld_busy),
        .cp_busy       (cp_busy),
        .proto_err     (proto_err)
    );

    // Layer FSM state register.
    always_ff @(posedge clki) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Layer FSM next-state: zero-tile layers go straight to S_DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_tiles != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request generation: requests are registered, held until ack, payload frozen while high.
    always_ff @(posedge clki) begin
        if (rst) begin
            num_tiles_reg   <= '0;
            ld_cnt_reg      <= '0;
            cp_cnt_reg      <= '0;
            ld_req_reg      <= 1'b0;
            ld_bank_reg     <= 1'b0;
            ld_idx_reg      <= '0;
            cp_req_reg      <= 1'b0;
            cp_bank_reg     <= 1'b0;
            cp_idx_reg      <= '0;
            cp_last_reg     <= 1'b0;
            cp_last_out_reg <= 1'b0;
        end else if (start_acc) begin
            num_tiles_reg   <= num_tiles;
            ld_cnt_reg      <= '0;
            cp_cnt_reg      <= '0;
            ld_req_reg      <= 1'b0;
            cp_req_reg      <= 1'b0;
            cp_last_reg     <= 1'b0;
            cp_last_out_reg <= 1'b0;
        end else begin
            if (ld_fire) begin
                ld_req_reg  <= 1'b0;
            end else if (ld_issue) begin
                ld_req_reg  <= 1'b1;
                ld_bank_reg <= ld_ptr;
                ld_idx_reg  <= ld_cnt_reg;
                ld_cnt_reg  <= ld_cnt_reg + TCW'(1);
            end
            if (cp_fire) begin
                cp_req_reg      <= 1'b0;
                cp_last_reg     <= 1'b0;
                cp_last_out_reg <= cp_last_reg;
            end else if (cp_issue) begin
                cp_req_reg  <= 1'b1;
                cp_bank_reg <= cp_ptr;
                cp_idx_reg  <= cp_cnt_reg;
                cp_last_reg <= (cp_cnt_reg == num_tiles_reg - TCW'(1));
                cp_cnt_reg  <= cp_cnt_reg + TCW'(1);
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [Perf_Width-1:0] stall_ld_reg;
    logic [Perf_Width-1:0] stall_cp_reg;
    logic                  ld_stalled;
    logic                  cp_stalled;

    // The compute-pointer bank can never be COMPUTING, so "not FULL" means EMPTY or LOADING.
    assign ld_stalled = (state_reg == S_RUN) && (ld_cnt_reg < num_tiles_reg) &&
                        !ld_req_reg && !ld_busy && !ld_bank_empty;
    assign cp_stalled = (state_reg == S_RUN) && (cp_cnt_reg < num_tiles_reg) && !cp_bank_full;

    // Saturating stall counters, cleared on each accepted start.
    always_ff @(posedge clki) begin
        if (rst || start_acc) begin
            stall_ld_reg <= '0;
            stall_cp_reg <= '0;
        end else begin
            if (ld_stalled && (stall_ld_reg != '1)) begin
                stall_ld_reg <= stall_ld_reg + Perf_Width'(1);
            end
            if (cp_stalled && (stall_cp_reg != '1)) begin
                stall_cp_reg <= stall_cp_reg + Perf_Width'(1);
            end
        end
    end

    assign stall_ld = stall_ld_reg;
    assign stall_cp = stall_cp_reg;
`endif

    assign ld_req      = ld_req_reg;
    assign ld_bank     = ld_bank_reg;
    assign ld_tile_idx = ld_idx_reg;
    assign cp_req      = cp_req_reg;
    assign cp_bank     = cp_bank_reg;
    assign cp_tile_idx = cp_idx_reg;
    assign cp_last     = cp_last_reg;
    assign busy        = (state_reg == S_RUN);
    assign layer_done  = (state_reg == S_DONE);

endmodule

// File: tb/tb_tile_sched.sv
// Testbench for tile_sched: directed latency/corner steps plus randomized engine
// behaviour checked against a tile-order reference model.
module tb_tile_sched;

    localparam int TCW = 10;

    logic           clki = 1'b0;
    logic           rst;
    logic           start;
    logic [TCW-1:0] num_tiles;
    logic           ld_req;
    logic           ld_ack;
    logic           ld_bank;
    logic [TCW-1:0] ld_tile_idx;
    logic           ld_done;
    logic           cp_req;
    logic           cp_ack;
    logic           cp_bank;
    logic [TCW-1:0] cp_tile_idx;
    logic           cp_last;
    logic           cp_done;
    logic           busy;
    logic           layer_done;
    logic           proto_err;
`ifdef PERF_CNT_EN
    logic [31:0]    stall_ld;
    logic [31:0]    stall_cp;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clki = ~clki;

    tile_sched #(.Tile_Cnt_Width(TCW)) dut (
        .clki        (clki),
        .rst         (rst),
        .start       (start),
        .num_tiles   (num_tiles),
        .ld_req      (ld_req),
        .ld_ack      (ld_ack),
        .ld_bank     (ld_bank),
        .ld_tile_idx (ld_tile_idx),
        .ld_done     (ld_done),
        .cp_req      (cp_req),
        .cp_ack      (cp_ack),
        .cp_bank     (cp_bank),
        .cp_tile_idx (cp_tile_idx),
        .cp_last     (cp_last),
        .cp_done     (cp_done),
`ifdef PERF_CNT_EN
        .stall_ld    (stall_ld),
        .stall_cp    (stall_cp),
`endif
        .busy        (busy),
        .layer_done  (layer_done),
        .proto_err   (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ld_req"}, ld_req, 0);
        chk({tag, "_cp_req"}, cp_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_layer_done"}, layer_done, 0);
    endtask

    // Reference model: tile k loads into and computes from bank k%2; load k needs the
    // compute of tile k-2 released; compute k needs load k finished; layer_done follows
    // the last compute release by one cycle.
    task automatic run_layer(input int n, input bit do_start, input int ack_max,
                             input int ld_dly_max, input int cp_dly_min, input int cp_dly_max);
        int ld_iss = 0, cp_iss = 0, ld_dn = 0, cp_dn = 0;
        int ld_t = -1, cp_t = -1, cyc = 0;
        bit ld_seen = 0, cp_seen = 0, ld_ack_prev = 0, cp_ack_prev = 0, fin = 0, ended = 0;
        logic [TCW:0] ld_cap = '0, cp_cap = '0;
        if (do_start) begin
            start = 1; num_tiles = TCW'(n);
            @(negedge clki);
            start = 0; num_tiles = TCW'($urandom_range(0, 15));
        end
        while (!ended && cyc < 4000) begin
            chk("run_busy", busy, !fin);
            chk("run_layer_done", layer_done, fin);
            if (fin) begin
                ended = 1;
            end else begin
                if (ld_ack_prev) chk("ld_req_drop", ld_req, 0);
                if (cp_ack_prev) chk("cp_req_drop", cp_req, 0);
                if (ld_req && !ld_seen) begin
                    chk("ld_bank_order", ld_bank, ld_iss % 2);
                    chk("ld_idx_order", ld_tile_idx, ld_iss);
                    chk("ld_within_layer", ld_iss < n, 1);
                    chk("ld_bank_released", cp_dn >= ld_iss - 1, 1);
                    ld_cap = {ld_bank, ld_tile_idx};
                    ld_seen = 1;
                end else if (ld_req) begin
                    chk("ld_stable", {ld_bank, ld_tile_idx}, ld_cap);
                end
                if (cp_req && !cp_seen) begin
                    chk("cp_bank_order", cp_bank, cp_iss % 2);
                    chk("cp_idx_order", cp_tile_idx, cp_iss);
                    chk("cp_last", cp_last, cp_iss == n - 1);
                    chk("cp_bank_loaded", ld_dn >= cp_iss + 1, 1);
                    cp_cap = {cp_bank, cp_tile_idx};
                    cp_seen = 1;
                end else if (cp_req) begin
                    chk("cp_stable", {cp_bank, cp_tile_idx}, cp_cap);
                end
                ld_ack = 0; ld_done = 0; cp_ack = 0; cp_done = 0;
                ld_ack_prev = 0; cp_ack_prev = 0;
                if (ld_t == 0) begin
                    ld_done = 1; ld_dn++; ld_t = -1;
                end else if (ld_t > 0) begin
                    ld_t--;
                end
                if (cp_t == 0) begin
                    cp_done = 1; cp_dn++; cp_t = -1;
                    if (cp_dn == n) fin = 1;
                end else if (cp_t > 0) begin
                    cp_t--;
                end
                if (ld_req && $urandom_range(0, ack_max) == 0) begin
                    ld_ack = 1; ld_iss++; ld_seen = 0; ld_ack_prev = 1;
                    ld_t = $urandom_range(0, ld_dly_max);
                end else if (!ld_req && $urandom_range(0, 7) == 0) begin
                    ld_ack = 1;
                end
                if (cp_req && $urandom_range(0, ack_max) == 0) begin
                    cp_ack = 1; cp_iss++; cp_seen = 0; cp_ack_prev = 1;
                    cp_t = $urandom_range(cp_dly_min, cp_dly_max);
                end else if (!cp_req && $urandom_range(0, 7) == 0) begin
                    cp_ack = 1;
                end
                @(negedge clki);
                cyc++;
            end
        end
        ld_ack = 0; ld_done = 0; cp_ack = 0; cp_done = 0;
        chk("layer_completed", ended, 1);
        chk("ld_count", ld_iss, n);
        chk("cp_count", cp_iss, n);
        chk("run_proto_err", proto_err, 0);
        $display("layer n=%0d cycles=%0d loads=%0d computes=%0d", n, cyc, ld_iss, cp_iss);
`ifdef PERF_CNT_EN
        if (cp_dly_min >= 50) chk("stall_ld_ge40", stall_ld >= 40, 1);
`endif
        @(negedge clki);
        chk("layer_done_once", layer_done, 0);
        chk("idle_after_layer", busy, 0);
    endtask

    initial begin
        rst = 1; start = 0; num_tiles = '0;
        ld_ack = 0; ld_done = 0; cp_ack = 0; cp_done = 0;
        repeat (3) @(negedge clki);
        rst = 0;
        chk_idle_outputs("reset");
        chk("reset_proto_err", proto_err, 0);
        chk("reset_ld_idx", ld_tile_idx, 0);
        $display("reset state checked");

        // Single tile: exact latency of every handshake.
        start = 1; num_tiles = 1;
        @(negedge clki); start = 0;
        chk("t1_busy_after_start", busy, 1);
        chk("t1_no_ld_req_yet", ld_req, 0);
        @(negedge clki);
        chk("t1_ld_req", ld_req, 1);
        chk("t1_ld_bank", ld_bank, 0);
        chk("t1_ld_idx", ld_tile_idx, 0);
        ld_ack = 1;
        @(negedge clki); ld_ack = 0;
        chk("t1_ld_req_drop", ld_req, 0);
        ld_done = 1;
        @(negedge clki); ld_done = 0;
        chk("t1_cp_req_not_yet", cp_req, 0);
        @(negedge clki);
        chk("t1_cp_req", cp_req, 1);
        chk("t1_cp_bank", cp_bank, 0);
        chk("t1_cp_idx", cp_tile_idx, 0);
        chk("t1_cp_last", cp_last, 1);
        cp_ack = 1;
        @(negedge clki); cp_ack = 0;
        chk("t1_cp_req_drop", cp_req, 0);
        cp_done = 1;
        @(negedge clki); cp_done = 0;
        chk("t1_layer_done", layer_done, 1);
        chk("t1_busy_fall", busy, 0);
        @(negedge clki);
        chk("t1_layer_done_pulse", layer_done, 0);
        $display("single-tile layer checked");

        // Zero tiles: straight to layer_done, no requests.
        start = 1; num_tiles = 0;
        @(negedge clki); start = 0;
        chk("t0_layer_done", layer_done, 1);
        chk("t0_busy", busy, 0);
        chk("t0_ld_req", ld_req, 0);
        @(negedge clki);
        chk("t0_layer_done_pulse", layer_done, 0);
        chk("t0_cp_req", cp_req, 0);
        $display("zero-tile layer checked");

        // Stray cp_done sets proto_err; next start clears it; start while busy ignored.
        cp_done = 1;
        @(negedge clki); cp_done = 0;
        chk("stray_proto_err", proto_err, 1);
        start = 1; num_tiles = 2;
        @(negedge clki); start = 0;
        chk("start_clears_proto_err", proto_err, 0);
        chk("busy_n2", busy, 1);
        start = 1; num_tiles = 5;
        @(negedge clki); start = 0;
        run_layer(2, 0, 2, 3, 0, 3);

        // Instant acks and dones.
        run_layer(4, 1, 0, 0, 0, 0);

        // Slow compute: third load must wait for bank 0 to be released.
        run_layer(3, 1, 0, 0, 50, 50);

        // Reset in the middle of a layer.
        start = 1; num_tiles = 4;
        @(negedge clki); start = 0;
        for (int i = 0; i < 20 && !ld_req; i++) @(negedge clki);
        chk("rst_tile0_ld_req", ld_req, 1);
        ld_ack = 1;
        @(negedge clki); ld_ack = 0; ld_done = 1;
        @(negedge clki); ld_done = 0;
        for (int i = 0; i < 20 && !ld_req; i++) @(negedge clki);
        chk("rst_tile1_ld_req", ld_req, 1);
        chk("rst_tile1_ld_bank", ld_bank, 1);
        ld_ack = 1;
        @(negedge clki); ld_ack = 0; rst = 1;
        @(negedge clki); rst = 0;
        chk_idle_outputs("midrst");
        chk("midrst_proto_err", proto_err, 0);
        chk("midrst_cp_last", cp_last, 0);
        repeat (3) @(negedge clki);
        chk("midrst_no_layer_done", layer_done, 0);
        $display("mid-layer reset checked");
        run_layer(2, 1, 1, 2, 0, 2);

        // Randomized layers.
        for (int r = 0; r < 6; r++) begin
            run_layer($urandom_range(1, 9), 1, 3, 4, 0, 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
